// File: rtl/dds_pkg.sv
// Shared constants, quadrant/sequencer encodings and the quarter-wave ROM
// entry function used by the multi-channel DDS.
package dds_pkg;

    localparam int DEF_NCH     = 4;
    localparam int DEF_PHASE_W = 32;
    localparam int DEF_LUT_AW  = 8;
    localparam int DEF_OUT_W   = 16;

    typedef enum logic [1:0] {
        Q0 = 2'd0,
        Q1 = 2'd1,
        Q2 = 2'd2,
        Q3 = 2'd3
    } quad_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } seq_state_t;

    // round(amp * sin(pi/2 * (idx + 0.5) / 2^aw)); Taylor series keeps it a
    // plain constant function with no dependence on $sin.
    function automatic int lut_entry(input int idx, input int aw, input int ow);
        real x;
        real term;
        real sum;
        real amp;
        x    = 1.5707963267948966 * (real'(idx) + 0.5) / real'(1 << aw);
        term = x;
        sum  = x;
        for (int n = 1; n < 12; n++) begin
            term = -term * x * x / real'((2 * n) * (2 * n + 1));
            sum  = sum + term;
        end
        amp = real'((1 << (ow - 1)) - 1);
        return $rtoi(sum * amp + 0.5);
    endfunction

endpackage

// File: rtl/dds_quarter_lut.sv
// Quarter-wave sine magnitude ROM with two independent registered read ports
// (one for the sine address, one for the cosine address).
module dds_quarter_lut
    import dds_pkg::*;
#(
    parameter int LUT_AW = DEF_LUT_AW,
    parameter int OUT_W  = DEF_OUT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [LUT_AW-1:0] sin_addr,
    input  logic [LUT_AW-1:0] cos_addr,
    output logic [OUT_W-2:0]  sin_mag,
    output logic [OUT_W-2:0]  cos_mag
);

    logic [OUT_W-2:0] rom [2**LUT_AW];
    logic [OUT_W-2:0] sin_mag_q, sin_mag_d;
    logic [OUT_W-2:0] cos_mag_q, cos_mag_d;

    for (genvar i = 0; i < 2**LUT_AW; i++) begin : g_rom
        assign rom[i] = (OUT_W-1)'(lut_entry(i, LUT_AW, OUT_W));
    end

    always_comb begin
        sin_mag_d = rom[sin_addr];
        cos_mag_d = rom[cos_addr];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sin_mag_q <= '0;
            cos_mag_q <= '0;
        end else begin
            sin_mag_q <= sin_mag_d;
            cos_mag_q <= cos_mag_d;
        end
    end

    assign sin_mag = sin_mag_q;
    assign cos_mag = cos_mag_q;

endmodule

// File: rtl/dds_multi.sv
// Time-multiplexed NCH-channel DDS: per-channel phase accumulators walked once
// per sample frame, feeding a 3-stage quarter-wave sin/cos pipeline.
module dds_multi
    import dds_pkg::*;
#(
    parameter int NCH     = DEF_NCH,
    parameter int PHASE_W = DEF_PHASE_W,
    parameter int LUT_AW  = DEF_LUT_AW,
    parameter int OUT_W   = DEF_OUT_W,
    parameter int CH_W    = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    sample_tick,
    input  logic                    cfg_we,
    input  logic                    cfg_sel,
    input  logic [CH_W-1:0]         cfg_ch,
    input  logic [PHASE_W-1:0]      cfg_data,
    input  logic                    phase_clr,
    output logic                    busy,
    output logic                    out_valid,
    output logic [CH_W-1:0]         out_ch,
    output logic [1:0]              out_quad,
    output logic signed [OUT_W-1:0] sin,
    output logic signed [OUT_W-1:0] cos,
    output logic                    tick_overrun,
    output seq_state_t              dbg_state
);

    // Handshake: sample_tick is a one-cycle strobe taken only while busy=0;
    // out_valid marks each output cycle and there is no back-pressure.
    localparam logic [CH_W-1:0] LAST_CH = CH_W'(NCH - 1);

    seq_state_t state_q, state_d;
    logic [CH_W-1:0]    cnt_q, cnt_d;
    logic [PHASE_W-1:0] acc_q[NCH], acc_d[NCH];
    logic [PHASE_W-1:0] inc_sh_q[NCH], inc_sh_d[NCH];
    logic [PHASE_W-1:0] ofs_sh_q[NCH], ofs_sh_d[NCH];
    logic [PHASE_W-1:0] inc_act_q[NCH], inc_act_d[NCH];
    logic [PHASE_W-1:0] ofs_act_q[NCH], ofs_act_d[NCH];
    logic clr_pend_q, clr_pend_d, clr_frame_q, clr_frame_d, ovr_q, ovr_d;

    logic s0_v_q, s0_v_d;
    logic [CH_W-1:0] s0_ch_q, s0_ch_d;
    logic s1_v_q, s1_v_d, s1_sin_neg_q, s1_sin_neg_d, s1_cos_neg_q, s1_cos_neg_d;
    logic [CH_W-1:0] s1_ch_q, s1_ch_d;
    quad_t s1_quad_q, s1_quad_d;
    logic [LUT_AW-1:0] s1_sin_a_q, s1_sin_a_d, s1_cos_a_q, s1_cos_a_d;
    logic s2_v_q, s2_v_d, s2_sin_neg_q, s2_sin_neg_d, s2_cos_neg_q, s2_cos_neg_d;
    logic [CH_W-1:0] s2_ch_q, s2_ch_d;
    quad_t s2_quad_q, s2_quad_d;
    logic out_v_q, out_v_d;
    logic [CH_W-1:0] out_ch_q, out_ch_d;
    logic [1:0] out_quad_q, out_quad_d;
    logic signed [OUT_W-1:0] sin_q, sin_d, cos_q, cos_d;

    logic [PHASE_W-1:0] ph;
    logic [1:0] q, qc;
    logic [LUT_AW-1:0] a;
    logic ph_unused;
    logic [OUT_W-2:0] sin_mag, cos_mag;
    logic signed [OUT_W-1:0] sin_ext, cos_ext;

    always_comb begin
        inc_sh_d = inc_sh_q;
        ofs_sh_d = ofs_sh_q;
        for (int i = 0; i < NCH; i++) begin
            if (cfg_we && cfg_ch == CH_W'(i)) begin
                if (cfg_sel) ofs_sh_d[i] = cfg_data;
                else         inc_sh_d[i] = cfg_data;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        inc_act_d   = inc_act_q;
        ofs_act_d   = ofs_act_q;
        clr_frame_d = clr_frame_q;
        clr_pend_d  = clr_pend_q | phase_clr;
        ovr_d       = ovr_q | (sample_tick && state_q != S_IDLE);
        s0_v_d      = 1'b0;
        s0_ch_d     = s0_ch_q;
        case (state_q)
            S_IDLE: begin
                if (sample_tick) begin
                    state_d     = S_RUN;
                    cnt_d       = '0;
                    inc_act_d   = inc_sh_q;
                    ofs_act_d   = ofs_sh_q;
                    clr_frame_d = clr_pend_q;
                    clr_pend_d  = phase_clr;
                    if (clr_pend_q) ovr_d = 1'b0;
                end
            end
            S_RUN: begin
                // A pending clear makes each channel restart from its increment.
                for (int i = 0; i < NCH; i++) begin
                    if (cnt_q == CH_W'(i))
                        acc_d[i] = (clr_frame_q ? '0 : acc_q[i]) + inc_act_q[i];
                end
                s0_v_d  = 1'b1;
                s0_ch_d = cnt_q;
                if (cnt_q == LAST_CH) state_d = S_DRAIN;
                else                  cnt_d   = cnt_q + 1'b1;
            end
            S_DRAIN: begin
                if (s2_v_q && s2_ch_q == LAST_CH) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        ph = '0;
        for (int i = 0; i < NCH; i++) begin
            if (s0_ch_q == CH_W'(i)) ph = acc_q[i] + ofs_act_q[i];
        end
        q  = ph[PHASE_W-1 -: 2];
        a  = ph[PHASE_W-3 -: LUT_AW];
        qc = q + 2'd1;
        s1_v_d       = s0_v_q;
        s1_ch_d      = s0_ch_q;
        s1_quad_d    = quad_t'(q);
        s1_sin_a_d   = q[0] ? ~a : a;
        s1_sin_neg_d = q[1];
        s1_cos_a_d   = qc[0] ? ~a : a;
        s1_cos_neg_d = qc[1];
        s2_v_d       = s1_v_q;
        s2_ch_d      = s1_ch_q;
        s2_quad_d    = s1_quad_q;
        s2_sin_neg_d = s1_sin_neg_q;
        s2_cos_neg_d = s1_cos_neg_q;
    end

    assign ph_unused = ^ph[PHASE_W-3-LUT_AW:0];

    dds_quarter_lut #(.LUT_AW(LUT_AW), .OUT_W(OUT_W)) u_lut (
        .clk      (clk),
        .rst      (rst),
        .sin_addr (s1_sin_a_q),
        .cos_addr (s1_cos_a_q),
        .sin_mag  (sin_mag),
        .cos_mag  (cos_mag)
    );

    // Mirrored half-step table never reaches full scale, so negation is safe.
    always_comb begin
        sin_ext    = signed'({1'b0, sin_mag});
        cos_ext    = signed'({1'b0, cos_mag});
        out_v_d    = s2_v_q;
        out_ch_d   = out_ch_q;
        out_quad_d = out_quad_q;
        sin_d      = sin_q;
        cos_d      = cos_q;
        if (s2_v_q) begin
            out_ch_d   = s2_ch_q;
            out_quad_d = s2_quad_q;
            sin_d      = s2_sin_neg_q ? -sin_ext : sin_ext;
            cos_d      = s2_cos_neg_q ? -cos_ext : cos_ext;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            clr_pend_q  <= 1'b0;
            clr_frame_q <= 1'b0;
            ovr_q       <= 1'b0;
            for (int i = 0; i < NCH; i++) begin
                acc_q[i]     <= '0;
                inc_sh_q[i]  <= '0;
                ofs_sh_q[i]  <= '0;
                inc_act_q[i] <= '0;
                ofs_act_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            clr_pend_q  <= clr_pend_d;
            clr_frame_q <= clr_frame_d;
            ovr_q       <= ovr_d;
            acc_q       <= acc_d;
            inc_sh_q    <= inc_sh_d;
            ofs_sh_q    <= ofs_sh_d;
            inc_act_q   <= inc_act_d;
            ofs_act_q   <= ofs_act_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s0_v_q <= 1'b0; s0_ch_q <= '0;
            s1_v_q <= 1'b0; s1_ch_q <= '0; s1_quad_q <= Q0;
            s1_sin_a_q <= '0; s1_cos_a_q <= '0;
            s1_sin_neg_q <= 1'b0; s1_cos_neg_q <= 1'b0;
            s2_v_q <= 1'b0; s2_ch_q <= '0; s2_quad_q <= Q0;
            s2_sin_neg_q <= 1'b0; s2_cos_neg_q <= 1'b0;
            out_v_q <= 1'b0; out_ch_q <= '0; out_quad_q <= '0;
            sin_q <= '0; cos_q <= '0;
        end else begin
            s0_v_q <= s0_v_d; s0_ch_q <= s0_ch_d;
            s1_v_q <= s1_v_d; s1_ch_q <= s1_ch_d; s1_quad_q <= s1_quad_d;
            s1_sin_a_q <= s1_sin_a_d; s1_cos_a_q <= s1_cos_a_d;
            s1_sin_neg_q <= s1_sin_neg_d; s1_cos_neg_q <= s1_cos_neg_d;
            s2_v_q <= s2_v_d; s2_ch_q <= s2_ch_d; s2_quad_q <= s2_quad_d;
            s2_sin_neg_q <= s2_sin_neg_d; s2_cos_neg_q <= s2_cos_neg_d;
            out_v_q <= out_v_d; out_ch_q <= out_ch_d; out_quad_q <= out_quad_d;
            sin_q <= sin_d; cos_q <= cos_d;
        end
    end

    assign busy         = (state_q != S_IDLE);
    assign out_valid    = out_v_q;
    assign out_ch       = out_ch_q;
    assign out_quad     = out_quad_q;
    assign sin          = sin_q;
    assign cos          = cos_q;
    assign tick_overrun = ovr_q;
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_dds_multi.sv
// Self-checking bench for dds_multi: directed scenarios plus random frames,
// compared against a frame-level trigonometric reference model.
module tb_dds_multi;
    import dds_pkg::*;

    localparam int NCH = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, sample_tick, cfg_we, cfg_sel, phase_clr;
    logic [1:0]  cfg_ch;
    logic [31:0] cfg_data;
    logic        busy, out_valid, tick_overrun;
    logic [1:0]  out_ch, out_quad;
    logic [15:0] sin_w, cos_w;
    seq_state_t  dbg_state;

    dds_multi #(.NCH(NCH)) dut (
        .clk          (clk),
        .rst          (rst),
        .sample_tick  (sample_tick),
        .cfg_we       (cfg_we),
        .cfg_sel      (cfg_sel),
        .cfg_ch       (cfg_ch),
        .cfg_data     (cfg_data),
        .phase_clr    (phase_clr),
        .busy         (busy),
        .out_valid    (out_valid),
        .out_ch       (out_ch),
        .out_quad     (out_quad),
        .sin          (sin_w),
        .cos          (cos_w),
        .tick_overrun (tick_overrun),
        .dbg_state    (dbg_state)
    );

    int n_assert = 0;
    int n_fail   = 0;
    logic [35:0] exp_q[$];
    logic [31:0] acc_m[NCH];
    logic [31:0] inc_sh_m[NCH];
    logic [31:0] ofs_sh_m[NCH];
    bit clr_pend_m;
    bit ovr_m;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_assert++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int rnd(input real v);
        if (v >= 0.0) return $rtoi(v + 0.5);
        return -$rtoi(0.5 - v);
    endfunction

    // Output of a channel at phase ph: amplitude * sin/cos of the centre of the
    // (2 + LUT_AW)-bit phase bin, rounded to nearest.
    function automatic logic [35:0] exp_pack(input int ch, input logic [31:0] ph);
        logic [9:0] idx;
        real ang;
        int s;
        int c;
        idx = ph[31:22];
        ang = 2.0 * 3.14159265358979323846 * (real'(idx) + 0.5) / 1024.0;
        s   = rnd(32767.0 * $sin(ang));
        c   = rnd(32767.0 * $cos(ang));
        return {2'(ch), ph[31:30], 16'(s), 16'(c)};
    endfunction

    task automatic model_reset();
        for (int k = 0; k < NCH; k++) begin
            acc_m[k] = '0;
            inc_sh_m[k] = '0;
            ofs_sh_m[k] = '0;
        end
        clr_pend_m = 1'b0;
        ovr_m = 1'b0;
        exp_q.delete();
    endtask

    task automatic cfg_write(input bit sel, input logic [1:0] ch, input logic [31:0] data);
        cfg_we = 1'b1; cfg_sel = sel; cfg_ch = ch; cfg_data = data;
        step();
        cfg_we = 1'b0;
        if (sel) ofs_sh_m[ch] = data;
        else     inc_sh_m[ch] = data;
    endtask

    task automatic request_clear();
        phase_clr = 1'b1;
        step();
        phase_clr = 1'b0;
        clr_pend_m = 1'b1;
    endtask

    task automatic run_frame(input bit cfg_now, input bit sel, input logic [1:0] ch,
                             input logic [31:0] data, input bit dbl_tick);
        logic [31:0] act_inc[NCH];
        logic [31:0] act_ofs[NCH];
        logic [35:0] e;
        int got;
        for (int k = 0; k < NCH; k++) begin
            act_inc[k] = inc_sh_m[k];
            act_ofs[k] = ofs_sh_m[k];
        end
        if (clr_pend_m) begin
            for (int k = 0; k < NCH; k++) acc_m[k] = '0;
            ovr_m = 1'b0;
            clr_pend_m = 1'b0;
        end
        for (int k = 0; k < NCH; k++) begin
            acc_m[k] = acc_m[k] + act_inc[k];
            exp_q.push_back(exp_pack(k, acc_m[k] + act_ofs[k]));
        end
        if (cfg_now) begin
            if (sel) ofs_sh_m[ch] = data;
            else     inc_sh_m[ch] = data;
        end

        sample_tick = 1'b1;
        cfg_we = cfg_now; cfg_sel = sel; cfg_ch = ch; cfg_data = data;
        step();
        sample_tick = 1'b0;
        cfg_we = 1'b0;
        check("busy_at_start", busy, 1);

        got = 0;
        for (int n = 1; n <= NCH + 4; n++) begin
            sample_tick = dbl_tick && (n == 3);
            step();
            if (sample_tick) ovr_m = 1'b1;
            sample_tick = 1'b0;
            check("out_valid_timing", out_valid, (n >= 4 && n <= NCH + 3));
            check("busy_timing", busy, (n < NCH + 3));
            if (out_valid === 1'b1) begin
                got++;
                check("exp_q_nonempty", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("out_ch", out_ch, e[35:34]);
                    check("out_quad", out_quad, e[33:32]);
                    check("sin", sin_w, e[31:16]);
                    check("cos", cos_w, e[15:0]);
                end
            end
        end
        check("outputs_per_frame", got, NCH);
        check("tick_overrun", tick_overrun, ovr_m);
        check("exp_q_drained", exp_q.size(), 0);
    endtask

    initial begin
        rst = 1'b0; sample_tick = 1'b0; cfg_we = 1'b0; cfg_sel = 1'b0;
        cfg_ch = '0; cfg_data = '0; phase_clr = 1'b0;
        model_reset();
        repeat (2) step();
        check("rst_busy", busy, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_ch", out_ch, 0);
        check("rst_out_quad", out_quad, 0);
        check("rst_sin", sin_w, 0);
        check("rst_cos", cos_w, 0);
        check("rst_overrun", tick_overrun, 0);
        check("rst_state", dbg_state, S_IDLE);
        rst = 1'b1;
        step();

        // All-zero configuration: every channel sits at phase 0.
        run_frame(0, 0, 0, 0, 0);

        // Quadrant offsets on ch1 and ch2.
        cfg_write(1, 2'd1, 32'h4000_0000);
        cfg_write(1, 2'd2, 32'h8000_0000);
        run_frame(0, 0, 0, 0, 0);
        cfg_write(1, 2'd1, 32'h0);
        cfg_write(1, 2'd2, 32'h0);

        // One full turn of ch0 in 16 frames, then one more past the wrap.
        cfg_write(0, 2'd0, 32'h1000_0000);
        repeat (17) run_frame(0, 0, 0, 0, 0);

        // Increment written on the tick edge applies one frame later; late tick overruns.
        run_frame(1, 0, 2'd0, 32'h2000_0000, 1);
        run_frame(0, 0, 0, 0, 0);

        // Phase clear after five frames restarts every accumulator at its increment.
        for (int k = 0; k < NCH; k++) cfg_write(0, 2'(k), 32'h0100_0000);
        repeat (5) run_frame(0, 0, 0, 0, 0);
        request_clear();
        run_frame(0, 0, 0, 0, 0);

        // Random configuration, clears, gaps and late ticks.
        repeat (24) begin
            repeat ($urandom_range(0, 3))
                cfg_write(1'($urandom_range(0, 1)), 2'($urandom_range(0, NCH - 1)), $urandom);
            if ($urandom_range(0, 4) == 0) request_clear();
            repeat ($urandom_range(0, 3)) step();
            run_frame(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      2'($urandom_range(0, NCH - 1)), $urandom, $urandom_range(0, 3) == 0);
        end

        // Reset in the middle of a frame.
        sample_tick = 1'b1;
        step();
        sample_tick = 1'b0;
        repeat (5) step();
        check("midframe_valid_before_rst", out_valid, 1);
        rst = 1'b0;
        #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_busy", busy, 0);
        check("midrst_sin", sin_w, 0);
        check("midrst_cos", cos_w, 0);
        check("midrst_overrun", tick_overrun, 0);
        model_reset();
        step();
        rst = 1'b1;
        step();
        repeat (6) begin
            step();
            check("no_output_after_rst", out_valid, 0);
        end
        run_frame(0, 0, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/dds_multi.md
Name: dds_multi

Overview:
- Time-multiplexed, parametrised successor to the single-channel dds block.
- Holds NCH independent 32-bit phase accumulators, each with its own increment and phase offset.
- Each sample frame it emits one quadrature pair (sin, cos) per channel from a shared quarter-wave LUT.
- Sits between the codec sample-rate strobe and the modulator/mixer datapath.

Parameters:
- NCH, 4, number of channels (1..16).
- PHASE_W, 32, accumulator and increment width.
- LUT_AW, 8, quarter-wave LUT address bits (2^LUT_AW entries).
- OUT_W, 16, signed output width.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- sample_tick  in  1  one-cycle strobe; starts a frame.
- cfg_we  in  1  configuration write strobe.
- cfg_sel  in  1  0 = phase increment, 1 = phase offset.
- cfg_ch  in  $clog2(NCH)  channel index for the write.
- cfg_data  in  PHASE_W  value written.
- phase_clr  in  1  request to zero all accumulators at the next frame start.
- busy  out  1  frame in progress.
- out_valid  out  1  sin/cos/out_ch/out_quad valid this cycle.
- out_ch  out  $clog2(NCH)  channel of the current output.
- out_quad  out  2  sin quadrant of the output phase.
- sin  out  OUT_W  signed sine.
- cos  out  OUT_W  signed cosine.
- tick_overrun  out  1  sticky flag: a tick arrived while busy.

Behaviour:
- Reset (rst=0, asynchronous):
  - all accumulators, shadow and active increments/offsets, pending clear, and pipeline registers are 0;
  - busy, out_valid, out_ch, out_quad, sin, cos and tick_overrun are all 0.
- Config path:
  - cfg_we writes the shadow register selected by cfg_ch and cfg_sel; out-of-range cfg_ch is ignored.
  - On the frame-start edge all shadows are copied to the active registers. A write coincident with the frame start lands in the shadow only and takes effect in the next frame.
  - phase_clr sets a pending flag; the flag is consumed at the next frame start.
- Frame start (edge E0): sample_tick=1 and busy=0 -> busy=1, channel counter = 0.
- Channel k (k = 0..NCH-1) advances its accumulator on edge E0+1+k:
  - if the clear is pending, acc := inc (accumulator treated as 0 before adding);
  - otherwise acc := acc + inc, modulo 2^PHASE_W (natural wrap).
  - The pipeline input for channel k is ph = acc_new + ofs (mod 2^PHASE_W).
- Pipeline: stage1 registers ph and the address decode, stage2 is the registered LUT read, stage3 applies the conditional negation and drives the outputs.
  - Channel k therefore has out_valid=1 after edge E0+4+k.
  - NCH consecutive valid cycles are produced, out_ch = 0..NCH-1 in order.
- busy falls after edge E0+4+NCH-1, i.e. together with the last out_valid.
  - A new tick is accepted on the cycle after busy falls.
  - A tick while busy=1 is ignored and sets tick_overrun.
  - tick_overrun clears only on reset or when the pending clear is consumed.
- Decode (sin):
  - q = ph[PHASE_W-1 -: 2], a = ph[PHASE_W-3 -: LUT_AW].
  - q=0 -> +L[a]; q=1 -> +L[~a]; q=2 -> -L[a]; q=3 -> -L[~a].
  - out_quad = q.
- Decode (cos): same rule using q+1 (mod 4) and the same a.
- LUT contents: L[i] = round((2^(OUT_W-1)-1) * sin(pi/2 * (i+0.5) / 2^LUT_AW)).
  - The half-step offset gives a symmetric mirror.
  - Negation can never overflow; |output| <= 2^(OUT_W-1)-1.
- Outputs hold their last values when out_valid=0.
- Reset mid-frame aborts the frame immediately; no partial output follows.

Decomposition:
- Package dds_pkg holds:
  - default parameter constants;
  - the quadrant encoding (Q0..Q3);
  - a function computing the LUT entry for elaboration-time ROM init.
- Sub-module dds_quarter_lut: dual-read-port ROM (sin and cos addresses), 1-cycle registered outputs, initialised from the dds_pkg function.
- Sequencer, accumulators and negation stay in dds_multi.

Test Plan:
- Reset, with defaults, all inc/ofs=0: tick -> 4 valid cycles at E0+4..E0+7, each sin=101, cos=32767, out_quad=0; busy high E0..E0+7.
- ch1 ofs=0x40000000, other channels 0: ch1 -> sin=32767, cos=-101, out_quad=1; ch2 ofs=0x80000000 -> sin=-101, cos=-32767, out_quad=2.
- ch0 inc=0x10000000, 16 frames: out_quad sequence 0,0,0,1,1,1,1,2,... and the accumulator wraps to 0 after frame 16 -> sin=101 again.
- cfg_we on the same edge as the tick: the old increment is used in that frame, the new one in the next; a second tick at E0+3 -> ignored, tick_overrun=1, output count unchanged.
- phase_clr after 5 frames with inc=0x01000000 -> next frame the accumulator equals inc (0x01000000), tick_overrun cleared.
- Assert rst=0 at E0+5 -> out_valid, busy, sin, cos all 0 immediately; the next tick after release behaves as the first-frame scenario.
